// File: rtl/instr_fetch_ctrl_if.sv
// Fetch-side bundle of instr_fetch_ctrl: ROM address/data, start and redirect
// controls, decode valid/ready handshake and status flags.
interface instr_fetch_ctrl_if #(
   parameter int ADDR_W = 7,
   parameter int DATA_W = 32
);
   logic              start;
   logic [ADDR_W-1:0] fetch_adrs;
   logic [DATA_W-1:0] instr_in;
   logic              redirect_valid;
   logic [ADDR_W-1:0] redirect_target;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_instr;
   logic [ADDR_W-1:0] out_pc;
   logic              halted;
   logic              misalign_err;

   modport master (
      input  start,
      output fetch_adrs,
      input  instr_in,
      input  redirect_valid,
      input  redirect_target,
      output out_valid,
      input  out_ready,
      output out_instr,
      output out_pc,
      output halted,
      output misalign_err
   );

   modport slave (
      output start,
      input  fetch_adrs,
      output instr_in,
      output redirect_valid,
      output redirect_target,
      input  out_valid,
      output out_ready,
      input  out_instr,
      input  out_pc,
      input  halted,
      input  misalign_err
   );
endinterface

// File: rtl/instr_fetch_ctrl.sv
// Program-counter sequencer for a combinational instruction ROM with a one-entry
// output slot to decode. FETCH_MISALIGN_TRAP_EN turns misaligned redirects into a halt.
module instr_fetch_ctrl #(
   parameter int ADDR_W   = 7,
   parameter int DATA_W   = 32,
   parameter int RESET_PC = 0,
   parameter int PC_STEP  = 4
) (
   input logic                clk,
   input logic                rst,
   instr_fetch_ctrl_if.master bus
);
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      STALL = 2'd2,
      HALT  = 2'd3
   } state_t;

   localparam logic [ADDR_W-1:0] RESET_PC_C = ADDR_W'(RESET_PC);
   localparam logic [ADDR_W-1:0] STEP_C     = ADDR_W'(PC_STEP);
   localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};
   localparam logic [DATA_W-1:0] ZERO_WORD  = {DATA_W{1'b0}};

   state_t            state_r, state_s;
   logic [ADDR_W-1:0] pc_r, pc_s;
   logic              valid_r, valid_s;
   logic [DATA_W-1:0] instr_r, instr_s;
   logic [ADDR_W-1:0] opc_r, opc_s;
   logic              halted_r;
   logic              err_r, err_s;
   logic              slot_free_s;
   logic              misaligned_s;
   logic [ADDR_W-1:0] target_s;

   // Redirect target conditioning: trap on misalignment, or silently word-align.
   always_comb begin
`ifdef FETCH_MISALIGN_TRAP_EN
      target_s     = bus.redirect_target;
      misaligned_s = (bus.redirect_target[1:0] != 2'b00);
`else
      target_s     = bus.redirect_target & ALIGN_MASK;
      misaligned_s = 1'b0;
`endif
   end

   // Next-state and slot update; STALL shares the FETCH rules and only records the wait.
   always_comb begin
      state_s     = state_r;
      pc_s        = pc_r;
      valid_s     = valid_r;
      instr_s     = instr_r;
      opc_s       = opc_r;
      err_s       = err_r;
      slot_free_s = !valid_r || bus.out_ready;
      case (state_r)
         IDLE: begin
            if (bus.start) begin
               state_s = FETCH;
            end else begin
               state_s = IDLE;
            end
         end
         FETCH, STALL: begin
            if (bus.redirect_valid) begin
               valid_s = 1'b0;
               if (misaligned_s) begin
                  err_s   = 1'b1;
                  state_s = HALT;
               end else begin
                  pc_s    = target_s;
                  state_s = FETCH;
               end
            end else if (!slot_free_s) begin
               state_s = STALL;
            end else if (bus.instr_in == ZERO_WORD) begin
               valid_s = 1'b0;
               state_s = HALT;
            end else begin
               valid_s = 1'b1;
               instr_s = bus.instr_in;
               opc_s   = pc_r;
               pc_s    = pc_r + STEP_C;
               state_s = FETCH;
            end
         end
         HALT: begin
            if (valid_r && bus.out_ready) begin
               valid_s = 1'b0;
            end else begin
               valid_s = valid_r;
            end
            if (bus.start) begin
               pc_s    = RESET_PC_C;
               state_s = FETCH;
            end else begin
               state_s = HALT;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State, pc, output slot and status registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r  <= IDLE;
         pc_r     <= RESET_PC_C;
         valid_r  <= 1'b0;
         instr_r  <= ZERO_WORD;
         opc_r    <= {ADDR_W{1'b0}};
         halted_r <= 1'b0;
         err_r    <= 1'b0;
      end else begin
         state_r  <= state_s;
         pc_r     <= pc_s;
         valid_r  <= valid_s;
         instr_r  <= instr_s;
         opc_r    <= opc_s;
         halted_r <= (state_s == HALT);
         err_r    <= err_s;
      end
   end

   assign bus.fetch_adrs   = pc_r;
   assign bus.out_valid    = valid_r;
   assign bus.out_instr    = instr_r;
   assign bus.out_pc       = opc_r;
   assign bus.halted       = halted_r;
   assign bus.misalign_err = err_r;
endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl: directed vector table from the test plan, then
// randomized traffic against a behavioural model plus a ROM-consistency scoreboard.
module tb_instr_fetch_ctrl;
`ifdef FETCH_MISALIGN_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif
   localparam int NV = 27;

   typedef struct {
      logic        rst;
      logic        start;
      logic        ready;
      logic        redir;
      logic [6:0]  tgt;
      logic        e_valid;
      logic        e_chkd;
      logic [6:0]  e_pc;
      logic [31:0] e_instr;
      logic        e_halted;
      logic        e_err;
      logic [6:0]  e_adrs;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] rom [0:31];
   vec_t        vecs [NV];
   int          n_checks = 0;
   int          n_fail = 0;

   // model state: mode 0 idle, 1 running (fetching or waiting), 2 halted
   int          m_mode, m_pc, m_opc;
   bit          m_valid, m_err;
   logic [31:0] m_instr;

   instr_fetch_ctrl_if #(.ADDR_W(7), .DATA_W(32)) bus ();

   instr_fetch_ctrl #(.ADDR_W(7), .DATA_W(32), .RESET_PC(0), .PC_STEP(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   assign bus.instr_in = rom[bus.fetch_adrs[6:2]];

   always #5 clk = ~clk;

   function automatic vec_t mk(input logic r, input logic st, input logic rdy, input logic rv,
                               input logic [6:0] tg, input logic ev, input logic ck,
                               input logic [6:0] epc, input logic [31:0] ein,
                               input logic eh, input logic ee, input logic [6:0] ea);
      vec_t v;
      v.rst = r; v.start = st; v.ready = rdy; v.redir = rv; v.tgt = tg;
      v.e_valid = ev; v.e_chkd = ck; v.e_pc = epc; v.e_instr = ein;
      v.e_halted = eh; v.e_err = ee; v.e_adrs = ea;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic model_step(input bit r, input bit st, input bit rdy, input bit rv, input int tg);
      logic [31:0] w;
      if (r) begin
         m_mode = 0; m_pc = 0; m_opc = 0; m_valid = 1'b0; m_instr = 32'h0; m_err = 1'b0;
      end else if (m_mode == 0) begin
         if (st) m_mode = 1;
      end else if (m_mode == 1) begin
         if (rv) begin
            m_valid = 1'b0;
            if (TRAP && (tg % 4) != 0) begin
               m_err = 1'b1;
               m_mode = 2;
            end else begin
               m_pc = tg - (tg % 4);
            end
         end else if (!m_valid || rdy) begin
            w = rom[m_pc / 4];
            if (w == 32'h0) begin
               m_valid = 1'b0;
               m_mode = 2;
            end else begin
               m_valid = 1'b1;
               m_instr = w;
               m_opc = m_pc;
               m_pc = (m_pc + 4) % 128;
            end
         end
      end else begin
         if (m_valid && rdy) m_valid = 1'b0;
         if (st) begin
            m_pc = 0;
            m_mode = 1;
         end
      end
   endtask

   initial begin
      bit r_rst, r_start, r_ready, r_redir;
      int r_tgt;

      bus.start = 1'b0;
      bus.out_ready = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_target = 7'h00;

      for (int i = 0; i < 32; i++) rom[i] = 32'h1000_0013 | (32'(i) << 12);
      rom[0]  = 32'h0045_0693;
      rom[1]  = 32'h0010_0713;
      rom[2]  = 32'h00b7_6463;
      rom[8]  = 32'h0118_5a63;
      rom[18] = 32'hfc1f_f06f;
      rom[19] = 32'h0000_0000;

      //             rst   start ready redir tgt     valid chk   pc      instr          halt  err   adrs
      vecs[0]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 7'h00, 1'b0, 1'b1, 7'd0,   32'h0,         1'b0, 1'b0, 7'd0);
      vecs[1]  = mk(1'b0, 1'b1, 1'b1, 1'b0, 7'h00, 1'b0, 1'b0, 7'd0,   32'h0,         1'b0, 1'b0, 7'd0);
      vecs[2]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 7'h00, 1'b1, 1'b1, 7'd0,   rom[0],        1'b0, 1'b0, 7'd4);
      vecs[3]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 7'h00, 1'b1, 1'b1, 7'd4,   rom[1],        1'b0, 1'b0, 7'd8);
      vecs[4]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 7'h00, 1'b1, 1'b1, 7'd8,   32'h00b76463,  1'b0, 1'b0, 7'd12);
      vecs[5]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 7'h00, 1'b1, 1'b1, 7'd8,   32'h00b76463,  1'b0, 1'b0, 7'd12);
      vecs[6]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 7'h00, 1'b1, 1'b1, 7'd8,   32'h00b76463,  1'b0, 1'b0, 7'd12);
      vecs[7]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 7'h00, 1'b1, 1'b1, 7'd8,   32'h00b76463,  1'b0, 1'b0, 7'd12);
      vecs[8]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 7'h00, 1'b1, 1'b1, 7'd12,  rom[3],        1'b0, 1'b0, 7'd16);
      vecs[9]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 7'h00, 1'b1, 1'b1, 7'd16,  rom[4],        1'b0, 1'b0, 7'd20);
      vecs[10] = mk(1'b0, 1'b0, 1'b0, 1'b1, 7'h20, 1'b0, 1'b0, 7'd0,   32'h0,         1'b0, 1'b0, 7'h20);
      vecs[11] = mk(1'b0, 1'b0, 1'b0, 1'b0, 7'h00, 1'b1, 1'b1, 7'h20,  32'h01185a63,  1'b0, 1'b0, 7'h24);
      vecs[12] = mk(1'b0, 1'b0, 1'b1, 1'b1, 7'd68, 1'b0, 1'b0, 7'd0,   32'h0,         1'b0, 1'b0, 7'd68);
      vecs[13] = mk(1'b0, 1'b1, 1'b1, 1'b0, 7'h00, 1'b1, 1'b1, 7'd68,  rom[17],       1'b0, 1'b0, 7'd72);
      vecs[14] = mk(1'b0, 1'b0, 1'b1, 1'b0, 7'h00, 1'b1, 1'b1, 7'd72,  32'hfc1ff06f,  1'b0, 1'b0, 7'd76);
      vecs[15] = mk(1'b0, 1'b0, 1'b1, 1'b0, 7'h00, 1'b0, 1'b0, 7'd0,   32'h0,         1'b1, 1'b0, 7'd76);
      vecs[16] = mk(1'b0, 1'b0, 1'b1, 1'b0, 7'h00, 1'b0, 1'b0, 7'd0,   32'h0,         1'b1, 1'b0, 7'd76);
      vecs[17] = mk(1'b0, 1'b1, 1'b1, 1'b0, 7'h00, 1'b0, 1'b0, 7'd0,   32'h0,         1'b0, 1'b0, 7'd0);
      vecs[18] = mk(1'b0, 1'b0, 1'b1, 1'b0, 7'h00, 1'b1, 1'b1, 7'd0,   rom[0],        1'b0, 1'b0, 7'd4);
      vecs[19] = mk(1'b0, 1'b0, 1'b1, 1'b1, 7'd124,1'b0, 1'b0, 7'd0,   32'h0,         1'b0, 1'b0, 7'd124);
      vecs[20] = mk(1'b0, 1'b0, 1'b1, 1'b0, 7'h00, 1'b1, 1'b1, 7'd124, rom[31],       1'b0, 1'b0, 7'd0);
      vecs[21] = mk(1'b0, 1'b0, 1'b0, 1'b0, 7'h00, 1'b1, 1'b1, 7'd124, rom[31],       1'b0, 1'b0, 7'd0);
      vecs[22] = mk(1'b1, 1'b0, 1'b0, 1'b0, 7'h00, 1'b0, 1'b1, 7'd0,   32'h0,         1'b0, 1'b0, 7'd0);
      vecs[23] = mk(1'b0, 1'b1, 1'b1, 1'b0, 7'h00, 1'b0, 1'b0, 7'd0,   32'h0,         1'b0, 1'b0, 7'd0);
      vecs[24] = mk(1'b0, 1'b0, 1'b1, 1'b0, 7'h00, 1'b1, 1'b1, 7'd0,   rom[0],        1'b0, 1'b0, 7'd4);
      vecs[25] = mk(1'b0, 1'b0, 1'b0, 1'b1, 7'h22, 1'b0, 1'b0, 7'd0,   32'h0,
                    TRAP, TRAP, TRAP ? 7'd4 : 7'h20);
      vecs[26] = mk(1'b0, 1'b0, 1'b1, 1'b0, 7'h00, !TRAP, !TRAP, 7'h20, rom[8],
                    TRAP, TRAP, TRAP ? 7'd4 : 7'h24);

      for (int i = 0; i < NV; i++) begin
         rst = vecs[i].rst;
         bus.start = vecs[i].start;
         bus.out_ready = vecs[i].ready;
         bus.redirect_valid = vecs[i].redir;
         bus.redirect_target = vecs[i].tgt;
         @(posedge clk);
         #1;
         check($sformatf("vec%0d out_valid", i), 32'(bus.out_valid), 32'(vecs[i].e_valid));
         check($sformatf("vec%0d halted", i), 32'(bus.halted), 32'(vecs[i].e_halted));
         check($sformatf("vec%0d misalign_err", i), 32'(bus.misalign_err), 32'(vecs[i].e_err));
         check($sformatf("vec%0d fetch_adrs", i), 32'(bus.fetch_adrs), 32'(vecs[i].e_adrs));
         if (vecs[i].e_chkd) begin
            check($sformatf("vec%0d out_pc", i), 32'(bus.out_pc), 32'(vecs[i].e_pc));
            check($sformatf("vec%0d out_instr", i), bus.out_instr, vecs[i].e_instr);
         end
      end

      for (int i = 0; i < 32; i++) rom[i] = ($urandom_range(0, 7) == 0) ? 32'h0 : ($urandom | 32'h1);
      for (int c = 0; c < 3000; c++) begin
         r_rst   = (c == 0) || ($urandom_range(0, 199) == 0);
         r_start = ($urandom_range(0, 15) == 0);
         r_redir = ($urandom_range(0, 9) == 0);
         r_tgt   = $urandom_range(0, 127);
         r_ready = ($urandom_range(0, 3) != 0);
         rst = r_rst;
         bus.start = r_start;
         bus.out_ready = r_ready;
         bus.redirect_valid = r_redir;
         bus.redirect_target = 7'(r_tgt);
         if (!r_rst && bus.out_valid && r_ready)
            check($sformatf("rand%0d accepted word vs rom", c), bus.out_instr, rom[bus.out_pc[6:2]]);
         @(posedge clk);
         model_step(r_rst, r_start, r_ready, r_redir, r_tgt);
         #1;
         check($sformatf("rand%0d out_valid", c), 32'(bus.out_valid), 32'(m_valid));
         check($sformatf("rand%0d halted", c), 32'(bus.halted), 32'(m_mode == 2));
         check($sformatf("rand%0d misalign_err", c), 32'(bus.misalign_err), 32'(m_err));
         check($sformatf("rand%0d fetch_adrs", c), 32'(bus.fetch_adrs), 32'(m_pc));
         if (m_valid) begin
            check($sformatf("rand%0d out_pc", c), 32'(bus.out_pc), 32'(m_opc));
            check($sformatf("rand%0d out_instr", c), bus.out_instr, m_instr);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/instr_fetch_ctrl.md
Name: instr_fetch_ctrl

Overview:
Program-counter sequencer for the 128-byte instruction ROM; drives the ROM byte address and forwards each fetched word to decode through a valid/ready handshake.
- ROM is combinational: `fetch_adrs` is presented and `instr_in` is sampled in the same cycle.
- Handles start, sequential fetch, downstream stall, branch/jump redirect with flush, and halt on an all-zero (end-of-program) word.
- Sits between the branch/execute logic and the instruction memory / decode stage.

Parameters:
- ADDR_W, 7, ROM byte-address width.
- DATA_W, 32, instruction width.
- RESET_PC, 0, fetch start address after reset or restart; must be a multiple of 4.
- PC_STEP, 4, byte increment per sequential fetch.

Ports:
- clk  in  1  Rising-edge clock.
- rst  in  1  Synchronous, active-high reset.
- start  in  1  Begin fetching (from IDLE) or restart (from HALT).
- fetch_adrs  out  ADDR_W  Byte address to the ROM; equals pc.
- instr_in  in  DATA_W  Word returned by the ROM for fetch_adrs, same cycle.
- redirect_valid  in  1  Branch/jump taken.
- redirect_target  in  ADDR_W  New byte address.
- out_valid  out  1  out_instr/out_pc hold a valid instruction.
- out_ready  in  1  Decode accepts the entry when out_valid && out_ready.
- out_instr  out  DATA_W  Registered instruction.
- out_pc  out  ADDR_W  Address of out_instr.
- halted  out  1  High while in HALT.
- misalign_err  out  1  Sticky misaligned-redirect flag; tied 0 without the macro.

Behaviour:
- Reset (rst=1 at a clk edge, in any state, including mid-stall or mid-redirect):
  - state=IDLE, pc=RESET_PC.
  - out_valid=0, out_instr=0, out_pc=0, halted=0, misalign_err=0.
- fetch_adrs=pc at all times (combinational).
- Output slot: a single register. It is "free" when out_valid=0, or when out_valid && out_ready in the current cycle.
- States:
  - IDLE: hold. start=1 -> FETCH next cycle; pc stays RESET_PC.
  - FETCH, slot free and instr_in != 0: capture out_instr<=instr_in, out_pc<=pc, out_valid<=1, pc<=pc+PC_STEP.
  - FETCH, slot not free: go to STALL; pc and the slot hold.
  - FETCH, slot free and instr_in == 0: do not capture. If the slot is being consumed this cycle, out_valid<=0. Go to HALT, halted<=1, pc holds.
  - STALL: hold until out_ready=1. On that cycle, apply the FETCH capture/halt rule to the current instr_in, then move to FETCH (or HALT).
  - HALT: any pending slot entry still drains via out_ready. start=1 -> pc<=RESET_PC, halted<=0, next state FETCH.
- Latency: ROM word to out_valid is 1 cycle. With out_ready held high, throughput is 1 instruction per cycle.
- Redirect (honoured only in FETCH and STALL; ignored in IDLE and HALT):
  - pc<=redirect_target, out_valid<=0 (flush, regardless of out_ready), no capture that cycle, next state FETCH.
  - Redirect has priority over capture, stall and zero-word halt.
  - First post-redirect word appears on out_* 2 cycles after redirect_valid.
- Arithmetic: pc+PC_STEP wraps modulo 2^ADDR_W (124 -> 0). Without the macro, redirect_target[1:0] is forced to 00.
- Handshake rules:
  - out_instr and out_pc stay stable while out_valid && !out_ready.
  - out_valid never drops without an accept, except on redirect or reset.
- start while in FETCH or STALL: ignored.

Optional Feature:
- Macro: FETCH_MISALIGN_TRAP_EN.
- Defined:
  - A redirect with redirect_target[1:0] != 00 is not taken.
  - misalign_err<=1 (sticky until rst), slot flushed, state->HALT, halted<=1, pc holds the faulting redirect's source pc.
  - start from HALT does not clear misalign_err.
- Undefined:
  - Low two target bits are forced to 00 and the redirect proceeds normally.
  - misalign_err is tied 0.

Test Plan:
- Reset, start=1, out_ready=1, ROM words 0x00450693, 0x00100713 at 0/4 -> out_pc 0,4 on consecutive cycles. First out_valid is 1 cycle after FETCH is entered.
- out_ready=0 for 3 cycles while out_pc=8 -> out_instr=0x00b76463 and out_pc=8 stable, fetch_adrs stays 12. Release -> out_pc=12 next cycle, no entry lost or duplicated.
- redirect_valid with target 0x20 while a slot entry for pc 0x10 is held, out_ready=0 -> out_valid=0 next cycle. out_pc=0x20 with instr 0x01185a63 one cycle later.
- Sequential fetch reaches address 76 (word 0) -> halted=1 and no zero word issued; word at 72 (0xfc1ff06f) still delivered. start -> restart at pc 0, halted=0.
- pc=124 with nonzero word -> next fetch_adrs=0. Assert rst during STALL -> all outputs return to reset values next cycle.
- With FETCH_MISALIGN_TRAP_EN, redirect target 0x22 -> misalign_err=1, halted=1, out_valid=0. Without the macro, the same redirect fetches address 0x20.
